// File: rtl/dfi_rd_capture.sv
// dfi_rd_capture: DFI read return path - rddata_en generation, AXI ID tagging, credit-protected R buffer.
// Optional macro SAL_RD_ERR_EN adds sticky o_err_unexp / o_err_ovf drop flags.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module dfi_rd_capture #(
    parameter int T_RDDATA_EN = 4,
    parameter int TAG_DEPTH   = 8,
    parameter int DATA_DEPTH  = 32
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_rd_issue,
    input  logic [`AXI_ID_WIDTH-1:0] i_rd_id,
    input  logic [3:0]               i_rd_len,
    output logic                     o_rd_ready,
    output logic                     o_dfi_rddata_en,
    input  logic                     i_dfi_rddata_valid,
    input  logic [63:0]              i_dfi_rddata,
    output logic                     o_r_valid,
    input  logic                     i_r_ready,
    output logic [`AXI_ID_WIDTH-1:0] o_r_id,
    output logic [63:0]              o_r_data,
    output logic                     o_r_last,
    output logic                     o_busy
`ifdef SAL_RD_ERR_EN
    ,
    output logic                     o_err_unexp,
    output logic                     o_err_ovf
`endif
);
    localparam int IW  = `AXI_ID_WIDTH;
    localparam int TW  = $clog2(TAG_DEPTH);
    localparam int DW  = $clog2(DATA_DEPTH);
    localparam int TCW = TW + 1;
    localparam int CW  = DW + 1;
    localparam int EW  = IW + 65;

    logic [IW+3:0] r_tag_mem [TAG_DEPTH];
    logic [TW:0]   r_tag_wp, r_tag_rp, w_tag_cnt;
    logic [3:0]    r_beat_cnt;
    logic [EW-1:0] r_dat_mem [DATA_DEPTH];
    logic [DW:0]   r_dat_wp, r_dat_rp, w_dat_cnt;
    logic [DW:0]   r_committed, w_add;
    logic [5:0]    r_en_cnt, w_en_next;
    logic [4:0]    w_push, w_tap;
    logic [IW+3:0] w_head;
    logic [EW-1:0] w_out;
    logic          w_acc, w_tag_full, w_tag_empty, w_beat, w_last;
    logic          w_dat_full, w_dat_wr, w_pop, w_dl_busy;

    always_comb begin
        w_tag_cnt   = r_tag_wp - r_tag_rp;
        w_tag_full  = w_tag_cnt == TCW'(TAG_DEPTH);
        w_tag_empty = r_tag_wp == r_tag_rp;
        w_dat_cnt   = r_dat_wp - r_dat_rp;
        w_dat_full  = w_dat_cnt == CW'(DATA_DEPTH);
        // Credit leaves room for one maximal 16-beat burst on top of what is committed
        o_rd_ready  = !rst && !w_tag_full && r_committed <= CW'(DATA_DEPTH - 16);
        w_acc       = i_rd_issue && o_rd_ready;
        w_push      = w_acc ? 5'(i_rd_len) + 5'd1 : 5'd0;
        w_add       = CW'(w_push);
        w_head      = r_tag_mem[r_tag_rp[TW-1:0]];
        w_beat      = i_dfi_rddata_valid && !w_tag_empty;
        w_last      = r_beat_cnt == w_head[3:0];
        w_dat_wr    = w_beat && !w_dat_full;
        w_out       = r_dat_mem[r_dat_rp[DW-1:0]];
        o_r_valid   = r_dat_wp != r_dat_rp;
        w_pop       = o_r_valid && i_r_ready;
        w_en_next   = (r_en_cnt != 6'd0 ? r_en_cnt - 6'd1 : 6'd0) + 6'(w_tap);
    end

    assign o_r_id          = w_out[EW-1:65];
    assign o_r_data        = w_out[64:1];
    assign o_r_last        = w_out[0];
    assign o_dfi_rddata_en = r_en_cnt != 6'd0;
    assign o_busy          = r_committed != '0 || r_en_cnt != 6'd0 || w_dl_busy;

    // r_en_cnt is the final stage of the enable delay, so only T_RDDATA_EN-1 slots sit ahead of it
    generate
        if (T_RDDATA_EN == 1) begin : g_nodl
            assign w_tap     = w_push;
            assign w_dl_busy = 1'b0;
        end else begin : g_dl
            logic [4:0] r_dl [T_RDDATA_EN-1];
            logic       w_any;
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < T_RDDATA_EN - 1; i++) r_dl[i] <= 5'd0;
                end else begin
                    r_dl[0] <= w_push;
                    for (int i = 1; i < T_RDDATA_EN - 1; i++) r_dl[i] <= r_dl[i-1];
                end
            end
            always_comb begin
                w_any = 1'b0;
                for (int i = 0; i < T_RDDATA_EN - 1; i++) w_any = w_any | (r_dl[i] != 5'd0);
            end
            assign w_tap     = r_dl[T_RDDATA_EN-2];
            assign w_dl_busy = w_any;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_acc) r_tag_mem[r_tag_wp[TW-1:0]] <= {i_rd_id, i_rd_len};
        if (w_dat_wr) r_dat_mem[r_dat_wp[DW-1:0]] <= {w_head[IW+3:4], i_dfi_rddata, w_last};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_wp    <= '0;
            r_tag_rp    <= '0;
            r_beat_cnt  <= 4'd0;
            r_dat_wp    <= '0;
            r_dat_rp    <= '0;
            r_committed <= '0;
            r_en_cnt    <= 6'd0;
        end else begin
            if (w_acc) r_tag_wp <= r_tag_wp + TCW'(1);
            if (w_beat) begin
                r_beat_cnt <= w_last ? 4'd0 : r_beat_cnt + 4'd1;
                if (w_last) r_tag_rp <= r_tag_rp + TCW'(1);
            end
            if (w_dat_wr) r_dat_wp <= r_dat_wp + CW'(1);
            if (w_pop) r_dat_rp <= r_dat_rp + CW'(1);
            r_committed <= r_committed + w_add - CW'(w_pop);
            r_en_cnt    <= w_en_next;
        end
    end

`ifdef SAL_RD_ERR_EN
    logic r_err_unexp, r_err_ovf;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_unexp <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            if (i_dfi_rddata_valid && w_tag_empty) r_err_unexp <= 1'b1;
            if ((w_beat && w_dat_full) || (i_rd_issue && !o_rd_ready)) r_err_ovf <= 1'b1;
        end
    end
    assign o_err_unexp = r_err_unexp;
    assign o_err_ovf   = r_err_ovf;
`endif
endmodule

// File: tb/tb_dfi_rd_capture.sv
// tb_dfi_rd_capture: directed stimulus with a queue scoreboard checked by an independent R-channel monitor.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module tb_dfi_rd_capture;
    localparam int IW = `AXI_ID_WIDTH;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [63:0]   data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0, rst = 1'b1, rd_issue = 1'b0, phy_v = 1'b0, r_ready = 1'b1;
    logic [IW-1:0] rd_id = '0;
    logic [3:0]    rd_len = '0;
    logic [63:0]   phy_d = '0;
    logic          rd_ready, en, r_valid, r_last, busy;
    logic [IW-1:0] r_id;
    logic [63:0]   r_data;
`ifdef SAL_RD_ERR_EN
    logic          err_unexp, err_ovf;
`endif

    int    n_tests = 0, n_fail = 0;
    beat_t exp_q[$];
    beat_t mon_e, prev_b;
    logic  prev_stall = 1'b0;

    always #5 clk = ~clk;

    dfi_rd_capture dut (
        .clk(clk), .rst(rst),
        .i_rd_issue(rd_issue), .i_rd_id(rd_id), .i_rd_len(rd_len), .o_rd_ready(rd_ready),
        .o_dfi_rddata_en(en), .i_dfi_rddata_valid(phy_v), .i_dfi_rddata(phy_d),
        .o_r_valid(r_valid), .i_r_ready(r_ready), .o_r_id(r_id), .o_r_data(r_data),
        .o_r_last(r_last), .o_busy(busy)
`ifdef SAL_RD_ERR_EN
        , .o_err_unexp(err_unexp), .o_err_ovf(err_ovf)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [IW-1:0] id, input logic [63:0] d, input logic last);
        beat_t b;
        b.id = id;
        b.data = d;
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic drain(input string name);
        int n = 0;
        r_ready = 1'b1;
        while (r_valid && n < 100) begin
            tick;
            n++;
        end
        check(name, r_valid, 0);
        tick;
    endtask

    // R-channel monitor: compares popped beats to the scoreboard and checks stall stability
    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall_valid", r_valid, 1);
            check("stall_data", r_data, prev_b.data);
            check("stall_id", r_id, prev_b.id);
            check("stall_last", r_last, prev_b.last);
        end
        if (r_valid && r_ready && !rst) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got id=%0h data=%0h with empty scoreboard", r_id, r_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("r_id", r_id, mon_e.id);
                check("r_data", r_data, mon_e.data);
                check("r_last", r_last, mon_e.last);
            end
        end
        prev_stall = r_valid && !r_ready && !rst;
        prev_b.id = r_id;
        prev_b.data = r_data;
        prev_b.last = r_last;
    end

    initial begin
        repeat (3) tick;
        check("rst_rd_ready", rd_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_en", en, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("post_rst_rd_ready", rd_ready, 1);
`ifdef SAL_RD_ERR_EN
        check("rst_err_unexp", err_unexp, 0);
        check("rst_err_ovf", err_ovf, 0);
`endif
        repeat (2) tick;

        // single read id=3 len=3: enable k=4..7, beats k=6..9, visible k=7..10
        for (int k = 0; k <= 12; k++) begin
            rd_issue = (k == 0);
            rd_id = 3;
            rd_len = 3;
            phy_v = (k >= 6 && k <= 9);
            phy_d = {32'h11110000, 32'(k)};
            if (phy_v) push(3, phy_d, k == 9);
            check("single_en", en, (k >= 4 && k <= 7));
            check("single_rvalid", r_valid, (k >= 7 && k <= 10));
            check("single_busy", busy, (k >= 1 && k <= 10));
            tick;
        end
        rd_issue = 1'b0;
        phy_v = 1'b0;
        check("single_busy_end", busy, 0);

        // back-to-back len=1 reads: A at k=0, B at k=2, enable merges k=4..7
        for (int k = 0; k <= 12; k++) begin
            rd_issue = (k == 0 || k == 2);
            rd_id = (k == 0) ? 1 : 2;
            rd_len = 1;
            phy_v = (k >= 6 && k <= 9);
            phy_d = {32'h22220000, 32'(k)};
            if (phy_v) push((k < 8) ? 1 : 2, phy_d, (k == 7 || k == 9));
            check("b2b_en", en, (k >= 4 && k <= 7));
            tick;
        end
        rd_issue = 1'b0;
        phy_v = 1'b0;
        check("b2b_busy_end", busy, 0);

        // credit: two len=15 reads fill DATA_DEPTH=32, third issue ignored
        r_ready = 1'b0;
        rd_issue = 1'b1;
        rd_len = 15;
        rd_id = 1;
        tick;
        check("credit_rdy_one", rd_ready, 1);
        rd_id = 2;
        tick;
        check("credit_rdy_two", rd_ready, 0);
        rd_id = 3;
        tick;
        rd_issue = 1'b0;
        check("credit_rdy_three", rd_ready, 0);
`ifdef SAL_RD_ERR_EN
        check("credit_err_ovf", err_ovf, 1);
        check("credit_err_unexp", err_unexp, 0);
`endif
        for (int b = 0; b < 32; b++) begin
            phy_v = 1'b1;
            phy_d = {32'h33330000, 32'(b)};
            push((b < 16) ? 1 : 2, phy_d, (b == 15 || b == 31));
            tick;
        end
        phy_v = 1'b0;
        check("credit_full_valid", r_valid, 1);
        check("credit_full_rdy", rd_ready, 0);
        r_ready = 1'b1;
        for (int p = 1; p <= 16; p++) begin
            tick;
            check("credit_rdy_return", rd_ready, (p == 16));
        end
        drain("credit_drain");
        check("credit_busy_end", busy, 0);

        // backpressure: len=7 with r_ready toggling
        for (int k = 0; k <= 20; k++) begin
            rd_issue = (k == 0);
            rd_id = 5;
            rd_len = 7;
            phy_v = (k >= 6 && k <= 13);
            phy_d = {32'h44440000, 32'(k * 3)};
            if (phy_v) push(5, phy_d, k == 13);
            r_ready = (k % 2) == 1;
            tick;
        end
        rd_issue = 1'b0;
        phy_v = 1'b0;
        drain("bp_drain");
        check("bp_busy_end", busy, 0);

        // unexpected beat with nothing outstanding
        phy_v = 1'b1;
        phy_d = 64'hDEAD_BEEF_0000_0001;
        tick;
        phy_v = 1'b0;
        check("unexp_rvalid", r_valid, 0);
        tick;
        check("unexp_rvalid2", r_valid, 0);
`ifdef SAL_RD_ERR_EN
        check("unexp_err", err_unexp, 1);
        repeat (3) tick;
        check("unexp_err_sticky", err_unexp, 1);
`endif

        // reset during the 2nd of 4 returning beats
        r_ready = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            rd_issue = (k == 0);
            rd_id = 6;
            rd_len = 3;
            phy_v = (k >= 6 && k <= 9);
            phy_d = {32'h55550000, 32'(k)};
            rst = (k == 7);
            if (k == 7) check("rstmid_pre_rvalid", r_valid, 1);
            if (k == 8) begin
                check("rstmid_rvalid", r_valid, 0);
                check("rstmid_en", en, 0);
                check("rstmid_busy", busy, 0);
            end
            if (k >= 9) check("rstmid_drop", r_valid, 0);
            tick;
        end
        rd_issue = 1'b0;
        phy_v = 1'b0;
        rst = 1'b0;
        r_ready = 1'b1;
`ifdef SAL_RD_ERR_EN
        check("rstmid_err_ovf", err_ovf, 0);
`endif
        repeat (2) tick;
        check("rstmid_busy_end", busy, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
